// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and a helper that classifies which operations launch a multi-cycle run.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: product or quotient/remainder of A and B,
// with divide-by-zero flagged so the caller can suppress the commit.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] temp_hi,
    output logic [WIDTH-1:0] temp_lo,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic        [WIDTH-1:0]   b_safe;
    logic signed [WIDTH-1:0]   q_s;
    logic signed [WIDTH-1:0]   r_s;
    logic        [WIDTH-1:0]   q_u;
    logic        [WIDTH-1:0]   r_u;
    logic                      b_zero;
    logic                      overflow;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves a value held and no latch is inferred.
    always_comb begin
        prod_s   = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
        prod_u   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        b_zero   = (B == '0);
        // Substitute a harmless divisor so the dividers never see zero.
        b_safe   = b_zero ? ONE : B;
        overflow = (A == MIN_NEG) && (B == '1);
        q_s      = $signed(A) / $signed(b_safe);
        r_s      = $signed(A) % $signed(b_safe);
        q_u      = A / b_safe;
        r_u      = A % b_safe;

        temp_hi  = '0;
        temp_lo  = '0;
        div_zero = is_div_op(mdu_op) && b_zero;

        case (mdu_op)
            MDU_MULT:  {temp_hi, temp_lo} = prod_s;
            MDU_MULTU: {temp_hi, temp_lo} = prod_u;
            MDU_DIV: begin
                if (overflow) begin
                    temp_lo = MIN_NEG;
                    temp_hi = '0;
                end else begin
                    temp_lo = q_s;
                    temp_hi = r_s;
                end
            end
            MDU_DIVU: begin
                temp_lo = q_u;
                temp_hi = r_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers;
// the result is computed at launch and committed after a fixed busy period.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] thi_q, thi_d;
    logic [WIDTH-1:0] tlo_q, tlo_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;
    logic             calc_dz;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .mdu_op   (mdu_op),
        .A        (A),
        .B        (B),
        .temp_hi  (calc_hi),
        .temp_lo  (calc_lo),
        .div_zero (calc_dz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        thi_d   = thi_q;
        tlo_d   = tlo_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (start && (is_mult_op(mdu_op) || is_div_op(mdu_op))) begin
                    state_d = RUN;
                    cnt_d   = is_mult_op(mdu_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    thi_d   = calc_hi;
                    tlo_d   = calc_lo;
                    dz_d    = calc_dz;
                end else if (mdu_op == MDU_MTHI) begin
                    hi_d = A;
                end else if (mdu_op == MDU_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                // start and MTHI/MTLO are deliberately ignored while running.
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!dz_q) begin
                        hi_d = thi_q;
                        lo_d = tlo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            thi_q   <= '0;
            tlo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            thi_q   <= thi_d;
            tlo_q   <= tlo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        result = '0;
        if (mdu_op == MDU_MFHI) result = hi_q;
        else if (mdu_op == MDU_MFLO) result = lo_q;
    end

endmodule
